// File: rtl/frame_write_arbiter_pkg.sv
// Shared types for the frame BRAM write arbiter: FSM state codes, requester IDs
// and default geometry of the {ymap,dist} frame image.
package frame_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 2;
  localparam int RD_LAT_DEF = 1;
  localparam int CNT_W_DEF  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_CLEAR = 2'd0,
    REQ_POINT = 2'd1,
    REQ_HUD   = 2'd2
  } req_id_t;

  function automatic logic [2:0] id_onehot(input req_id_t id);
    logic [2:0] oh;
    case (id)
      REQ_CLEAR: oh = 3'b001;
      REQ_POINT: oh = 3'b010;
      REQ_HUD:   oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/frame_write_arbiter_rr_pick2.sv
// Round-robin chooser between the point writer and the HUD overlay.
// The pointer names the requester preferred on the next contested grant.
module frame_write_arbiter_rr_pick2
  import frame_write_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_point,
  input  logic    req_hud,
  input  logic    take,
  output logic    valid,
  output req_id_t pick
);

  req_id_t rr_ptr_q;
  req_id_t rr_ptr_d;

  // Winner selection and pointer advance once a grant to 1 or 2 is taken
  always_comb begin
    valid    = req_point | req_hud;
    pick     = REQ_POINT;
    rr_ptr_d = rr_ptr_q;
    if (req_point && req_hud) begin
      pick = rr_ptr_q;
    end else if (req_hud) begin
      pick = REQ_HUD;
    end else begin
      pick = REQ_POINT;
    end
    if (take && valid) begin
      rr_ptr_d = (pick == REQ_POINT) ? REQ_HUD : REQ_POINT;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= REQ_POINT;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Single write port owner of the frame BRAM; arbitrates clear/point/HUD writers
// and optionally performs a read-modify-write that keeps the larger depth code.
module frame_write_arbiter
  import frame_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [2:0]        cmp,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int RD_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              cmp_q,   cmp_d;
  req_id_t           win_q,   win_d;
  logic [RD_W-1:0]   rd_q,    rd_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              accept_s;
  logic              rr_take_s;
  logic              rr_valid_s;
  req_id_t           rr_pick_s;
  req_id_t           win_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_cmp_s;

  frame_write_arbiter_rr_pick2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_point (req[1]),
    .req_hud   (req[2]),
    .take      (rr_take_s),
    .valid     (rr_valid_s),
    .pick      (rr_pick_s)
  );

  // Arbitration, only while idle: the clear engine always wins
  always_comb begin
    accept_s  = 1'b0;
    rr_take_s = 1'b0;
    win_s     = REQ_CLEAR;
    if (state_q == ST_IDLE) begin
      if (req[0]) begin
        accept_s = 1'b1;
        win_s    = REQ_CLEAR;
      end else if (rr_valid_s) begin
        accept_s  = 1'b1;
        rr_take_s = 1'b1;
        win_s     = rr_pick_s;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Winner operand mux
  always_comb begin
    sel_addr_s = addr0;
    sel_data_s = data0;
    sel_cmp_s  = cmp[0];
    case (win_s)
      REQ_CLEAR: begin
        sel_addr_s = addr0;
        sel_data_s = data0;
        sel_cmp_s  = cmp[0];
      end
      REQ_POINT: begin
        sel_addr_s = addr1;
        sel_data_s = data1;
        sel_cmp_s  = cmp[1];
      end
      REQ_HUD: begin
        sel_addr_s = addr2;
        sel_data_s = data2;
        sel_cmp_s  = cmp[2];
      end
      default: begin
        sel_addr_s = addr0;
        sel_data_s = data0;
        sel_cmp_s  = cmp[0];
      end
    endcase
  end

  // Next-state and transaction capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cmp_d   = cmp_q;
    win_d   = win_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d  = sel_addr_s;
          data_d  = sel_data_s;
          cmp_d   = sel_cmp_s;
          win_d   = win_s;
          rd_d    = RD_W'(RD_LAT - 1);
          state_d = sel_cmp_s ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_q == {RD_W{1'b0}}) begin
          state_d = ST_WRITE;
        end else begin
          rd_d = rd_q - RD_W'(1);
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Saturating write counter; a clear beats a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_WRITE) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Port drive decoded from the registered state; RMW merge is combinational
  always_comb begin
    bram_addr = addr_q;
    busy      = (state_q != ST_IDLE);
    bram_we   = 1'b0;
    gnt       = 3'b000;
    bram_din  = {DATA_W{1'b0}};
    if (state_q == ST_WRITE) begin
      bram_we  = 1'b1;
      gnt      = id_onehot(win_q);
      bram_din = (cmp_q && (bram_dout > data_q)) ? bram_dout : data_q;
    end else begin
      bram_we = 1'b0;
    end
  end

  assign wr_count = cnt_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      cmp_q   <= 1'b0;
      win_q   <= REQ_CLEAR;
      rd_q    <= {RD_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cmp_q   <= cmp_d;
      win_q   <= win_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Self-checking bench for frame_write_arbiter: vector table, corner sequences,
// and randomized requester traffic against a transaction-level model.
module tb_frame_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [12:0] addr0, addr1, addr2;
  logic [1:0]  data0, data1, data2;
  logic [2:0]  cmp;
  logic [2:0]  gnt;
  logic [12:0] bram_addr;
  logic [1:0]  bram_din;
  logic        bram_we;
  logic [1:0]  bram_dout;
  logic        busy;
  logic        cnt_clr;
  logic [13:0] wr_count;

  int total = 0;
  int bad   = 0;
  int exp_pref;

  logic [1:0]  mem [8192];
  logic        pre_en;
  logic [12:0] pre_addr;
  logic [1:0]  pre_val;

  typedef struct packed {
    logic [12:0] a;
    logic [1:0]  d;
    logic        c;
  } item_t;

  typedef struct {
    int          idx;
    logic [12:0] a;
    logic [1:0]  d;
    logic        c;
    logic [1:0]  pre;
    logic [1:0]  exp_din;
    int          exp_lat;
  } vec_t;

  vec_t  tbl [7];
  item_t items [3][16];
  int    len [3];
  int    head [3];
  logic [1:0] shadow [16];

  frame_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .cmp       (cmp),
    .gnt       (gnt),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .bram_dout (bram_dout),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // BRAM with one cycle read latency, read-before-write
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] mx(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic preload(input logic [12:0] a, input logic [1:0] v);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(posedge clk); @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic set_inputs(input int idx, input logic [12:0] a, input logic [1:0] d, input logic c);
    case (idx)
      0: begin addr0 = a; data0 = d; end
      1: begin addr1 = a; data1 = d; end
      default: begin addr2 = a; data2 = d; end
    endcase
    cmp[idx] = c;
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
    end while (gnt == 3'b000 && lat < 20);
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_txn(input string nm, input int idx, input logic [12:0] a, input logic [1:0] d,
                        input logic c, input logic [1:0] exp_din, input int exp_lat);
    int lat;
    logic [2:0] eg;
    set_inputs(idx, a, d, c);
    req = 3'b000;
    req[idx] = 1'b1;
    wait_gnt(lat);
    eg = 3'b001 << idx;
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_gnt"}, {29'd0, gnt}, {29'd0, eg});
    check({nm, "_we"}, {31'd0, bram_we}, 32'd1);
    check({nm, "_addr"}, {19'd0, bram_addr}, {19'd0, a});
    check({nm, "_din"}, {30'd0, bram_din}, {30'd0, exp_din});
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    if (idx != 0) exp_pref = 3 - idx;
    req = 3'b000;
    cmp = 3'b000;
    idle_cycle();
    check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({nm, "_we_after"}, {31'd0, bram_we}, 32'd0);
    check({nm, "_gnt_after"}, {29'd0, gnt}, 32'd0);
    check({nm, "_addr_hold"}, {19'd0, bram_addr}, {19'd0, a});
    check({nm, "_mem"}, {30'd0, mem[a]}, {30'd0, exp_din});
  endtask

  function automatic int exp_winner();
    bit p1, p2;
    if (head[0] < len[0]) return 0;
    p1 = head[1] < len[1];
    p2 = head[2] < len[2];
    if (p1 && p2) return exp_pref;
    if (p1) return 1;
    return 2;
  endfunction

  task automatic apply_heads();
    for (int i = 0; i < 3; i++) begin
      if (head[i] < len[i]) begin
        set_inputs(i, items[i][head[i]].a, items[i][head[i]].d, items[i][head[i]].c);
        req[i] = 1'b1;
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic random_round(input int r);
    int cyc, prev_g, w, exp_cyc, pend;
    item_t it;
    logic [1:0] ed;
    for (int i = 0; i < 16; i++) begin
      preload(13'h1000 + 13'(i), 2'd0);
      shadow[i] = 2'd0;
    end
    for (int i = 0; i < 3; i++) begin
      len[i] = $urandom_range(4, 12);
      head[i] = 0;
      for (int k = 0; k < 16; k++) begin
        items[i][k].a = 13'h1000 + 13'($urandom_range(0, 15));
        items[i][k].d = 2'($urandom_range(0, 3));
        items[i][k].c = 1'($urandom_range(0, 1));
      end
    end
    apply_heads();
    cyc = 0;
    prev_g = -1;
    pend = len[0] + len[1] + len[2];
    while (pend > 0 && cyc < 2000) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (gnt != 3'b000) begin
        w = exp_winner();
        it = items[w][head[w]];
        exp_cyc = prev_g + 1 + (it.c ? 2 : 1);
        ed = it.c ? mx(shadow[it.a[3:0]], it.d) : it.d;
        check($sformatf("rnd%0d_gnt", r), {29'd0, gnt}, 32'd1 << w);
        check($sformatf("rnd%0d_cycle", r), cyc, exp_cyc);
        check($sformatf("rnd%0d_addr", r), {19'd0, bram_addr}, {19'd0, it.a});
        check($sformatf("rnd%0d_din", r), {30'd0, bram_din}, {30'd0, ed});
        shadow[it.a[3:0]] = ed;
        head[w]++;
        pend--;
        if (w != 0) exp_pref = 3 - w;
        prev_g = cyc;
        apply_heads();
      end
    end
    check($sformatf("rnd%0d_drained", r), pend, 0);
    req = 3'b000;
    cmp = 3'b000;
    idle_cycle();
  endtask

  initial begin
    int lat, n, cyc;
    tbl[0] = '{1, 13'h0ABC, 2'd2, 1'b0, 2'd0, 2'd2, 1};
    tbl[1] = '{1, 13'h0100, 2'd1, 1'b1, 2'd3, 2'd3, 2};
    tbl[2] = '{1, 13'h0100, 2'd2, 1'b1, 2'd1, 2'd2, 2};
    tbl[3] = '{2, 13'h0055, 2'd2, 1'b1, 2'd2, 2'd2, 2};
    tbl[4] = '{0, 13'h1FFF, 2'd0, 1'b0, 2'd3, 2'd0, 1};
    tbl[5] = '{2, 13'h0000, 2'd1, 1'b1, 2'd0, 2'd1, 2};
    tbl[6] = '{0, 13'h0200, 2'd0, 1'b1, 2'd2, 2'd2, 2};

    rst = 1'b1; req = 3'b000; cmp = 3'b000; cnt_clr = 1'b0; pre_en = 1'b0;
    pre_addr = 13'd0; pre_val = 2'd0;
    addr0 = 13'd0; addr1 = 13'd0; addr2 = 13'd0;
    data0 = 2'd0; data1 = 2'd0; data2 = 2'd0;
    exp_pref = 1;
    repeat (3) @(negedge clk);
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_we", {31'd0, bram_we}, 32'd0);
    check("rst_addr", {19'd0, bram_addr}, 32'd0);
    check("rst_din", {30'd0, bram_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {18'd0, wr_count}, 32'd0);
    rst = 1'b0;
    idle_cycle();
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      preload(tbl[i].a, tbl[i].pre);
      do_txn($sformatf("vec%0d", i), tbl[i].idx, tbl[i].a, tbl[i].d, tbl[i].c,
             tbl[i].exp_din, tbl[i].exp_lat);
    end

    // clear engine hogs the port, then 1 and 2 alternate
    set_inputs(0, 13'h0010, 2'd1, 1'b0);
    set_inputs(1, 13'h0011, 2'd2, 1'b0);
    set_inputs(2, 13'h0012, 2'd3, 1'b0);
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(lat);
      check($sformatf("prio%0d_gnt", k), {29'd0, gnt}, 32'd1);
      check($sformatf("prio%0d_lat", k), lat, (k == 0) ? 1 : 2);
    end
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(lat);
      check($sformatf("rr%0d_gnt", k), {29'd0, gnt}, 32'd1 << exp_pref);
      check($sformatf("rr%0d_lat", k), lat, 2);
      exp_pref = 3 - exp_pref;
    end
    req = 3'b000;
    idle_cycle();

    // async reset in the middle of a read-modify-write
    preload(13'h0300, 2'd1);
    set_inputs(1, 13'h0300, 2'd2, 1'b1);
    req = 3'b010;
    idle_cycle();
    check("rmw_read_busy", {31'd0, busy}, 32'd1);
    check("rmw_read_we", {31'd0, bram_we}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_we", {31'd0, bram_we}, 32'd0);
    check("abort_gnt", {29'd0, gnt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {18'd0, wr_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_pref = 1;
    wait_gnt(lat);
    check("rearb_lat", lat, 2);
    check("rearb_gnt", {29'd0, gnt}, 32'd2);
    check("rearb_din", {30'd0, bram_din}, 32'd2);
    exp_pref = 2;
    req = 3'b000; cmp = 3'b000;
    idle_cycle();
    check("rearb_count", {18'd0, wr_count}, 32'd1);

    // inputs change during READ; captured transaction must win
    preload(13'h0123, 2'd1);
    set_inputs(1, 13'h0123, 2'd2, 1'b1);
    req = 3'b010;
    idle_cycle();
    addr1 = 13'h1FFF; data1 = 2'd0;
    wait_gnt(lat);
    check("capt_lat", lat, 1);
    check("capt_addr", {19'd0, bram_addr}, 32'h0123);
    check("capt_din", {30'd0, bram_din}, 32'd2);
    exp_pref = 2;
    req = 3'b000; cmp = 3'b000;
    idle_cycle();

    for (int r = 0; r < 3; r++) random_round(r);

    // counter saturation and clear priority
    cnt_clr = 1'b1;
    idle_cycle();
    cnt_clr = 1'b0;
    check("clr_count", {18'd0, wr_count}, 32'd0);
    set_inputs(0, 13'h0020, 2'd1, 1'b0);
    req = 3'b001;
    n = 0; cyc = 0;
    while (n < 16382 && cyc < 40000) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (gnt[0]) n++;
    end
    req = 3'b000;
    check("bulk_writes", n, 16382);
    idle_cycle();
    check("count_3ffe", {18'd0, wr_count}, 32'h3FFE);
    do_txn("sat_a", 0, 13'h0021, 2'd1, 1'b0, 2'd1, 1);
    check("count_3fff", {18'd0, wr_count}, 32'h3FFF);
    do_txn("sat_b", 0, 13'h0022, 2'd2, 1'b0, 2'd2, 1);
    check("count_held", {18'd0, wr_count}, 32'h3FFF);
    set_inputs(0, 13'h0023, 2'd3, 1'b0);
    req = 3'b001;
    wait_gnt(lat);
    check("clrw_gnt", {29'd0, gnt}, 32'd1);
    cnt_clr = 1'b1;
    req = 3'b000;
    idle_cycle();
    cnt_clr = 1'b0;
    check("clr_wins", {18'd0, wr_count}, 32'd0);
    do_txn("post_clr", 0, 13'h0024, 2'd1, 1'b0, 2'd1, 1);
    check("count_one", {18'd0, wr_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
